// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output, framing and overrun flags.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample point.
module uart_rx #(
  parameter int CLKS_PER_BIT = 101,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  localparam logic [13:0] RELOAD = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF   = 14'(HALF_BIT);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  state_e      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic        rxs;
  logic        busy;
  logic        tick;
  logic        smp;

`ifdef UART_RX_MAJORITY_EN
  logic        s1_q, s1_d;
  logic        s0_q, s0_d;
  logic        pend_q, pend_d;
`endif

  assign rxs  = sync2_q;
  assign busy = (state_q == S_START) || (state_q == S_DATA) ||
                (state_q == S_STOP);

`ifdef UART_RX_MAJORITY_EN
  // Collect the votes at counter 1 and 0; decide one cycle after 0.
  always_comb begin
    s1_d   = s1_q;
    s0_d   = s0_q;
    pend_d = 1'b0;
    if (busy && cnt_q == 14'd1) s1_d = rxs;
    if (busy && cnt_q == 14'd0) begin
      s0_d   = rxs;
      pend_d = 1'b1;
    end
    tick = pend_q;
    smp  = (s1_q & s0_q) | (s1_q & rxs) | (s0_q & rxs);
  end
`else
  // Single sample taken at the counter-zero cycle.
  always_comb begin
    tick = busy && (cnt_q == 14'd0);
    smp  = rxs;
  end
`endif

  // Next-state logic: synchroniser, bit timing, frame FSM and delivery.
  always_comb begin
    sync1_d = RX;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    if (busy) cnt_d = (cnt_q == 14'd0) ? RELOAD : cnt_q - 14'd1;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (!smp) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[idx_q] = smp;
          if (idx_q == 3'd7) state_d = S_STOP;
          else idx_d = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (smp) begin
            state_d = S_IDLE;
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            state_d = S_WAIT_HIGH;
            ferr_d  = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s1_q    <= 1'b1;
      s0_q    <= 1'b1;
      pend_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_MAJORITY_EN
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule
